// File: rtl/bubble_pkg.sv
// bubble_pkg: shared FSM encoding, SPI command, access codes and geometry for the bubble SPI loader.
//   Types     : state_t (loader FSM states)
//   Constants : SPI_READ_CMD, ACC_BOOT/ACC_USER (outbuffer ACCTYPE codes), BOOT_POS, PAGE_POS, USER_ORG
//   Function  : bit_span(pos, w4) -> buffer bits covered by pos positions at the given module width
package bubble_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_HOLD
    } state_t;

    localparam logic [7:0] SPI_READ_CMD = 8'h03;
    localparam logic [2:0] ACC_BOOT     = 3'b110;
    localparam logic [2:0] ACC_USER     = 3'b111;
    localparam int         BOOT_POS     = 1927;
    localparam int         PAGE_POS     = 584;
    localparam int         USER_ORG     = 7168;

    // Positions map to 2 or 4 consecutive bits depending on module width.
    function automatic logic [14:0] bit_span(input int pos, input logic w4);
        return w4 ? 15'(pos * 4) : 15'(pos * 2);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SPI mode-0 clock divider producing SCK and one-cycle rise/fall ticks.
//   MCLK   in  system clock
//   nRESET in  async active-low reset
//   en     in  run SCK; when low SCK is forced low and the divider restarts
//   rise   out high in the MCLK cycle whose closing edge raises SCK
//   fall   out high in the MCLK cycle whose closing edge lowers SCK
//   sck    out SCK level, idle low
module spi_sck_gen #(
    parameter int SCK_HALF = 2
) (
    input  logic MCLK,
    input  logic nRESET,
    input  logic en,
    output logic rise,
    output logic fall,
    output logic sck
);

    logic [7:0] cnt;
    logic       tc;

    assign tc   = en && cnt == 8'(SCK_HALF - 1);
    assign rise = tc && !sck;
    assign fall = tc && sck;

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else begin
            cnt <= tc ? '0 : cnt + 8'd1;
            sck <= sck ^ tc;
        end
    end

endmodule

// File: rtl/bubble_spi_loader.sv
// bubble_spi_loader: reads boot image or a user page from SPI NOR flash (READ 0x03, mode 0)
// and streams each bit into the bubble outbuffer write port.
//   MCLK, nRESET          clock, async active-low reset
//   BITWIDTH4             0 = 2-bit module, 1 = 4-bit module (sampled with LOADSTART)
//   LOADSTART/LOADTYPE    request pulse; 0 = boot image, 1 = user page
//   PAGENUM[10:0]         user page number
//   LOADBUSY, LOADDONE    busy level, one-cycle completion pulse
//   nCS, SCK, MOSI, MISO  SPI flash interface
//   nOUTBUFWRCLKEN        active-low one-cycle write strobe
//   OUTBUFWRADDR[14:0]    bit-sequential buffer address
//   OUTBUFWRDATA          write data
module bubble_spi_loader import bubble_pkg::*; #(
    parameter int          SCK_HALF    = 2,
    parameter logic [23:0] BOOT_BASE   = 24'h000000,
    parameter logic [23:0] PAGE_BASE   = 24'h010000,
    parameter int          PAGE_STRIDE = 256,
    parameter int          BOOT_POS    = bubble_pkg::BOOT_POS,
    parameter int          PAGE_POS    = bubble_pkg::PAGE_POS,
    parameter int          USER_ORG    = bubble_pkg::USER_ORG,
    parameter int          CS_HOLD     = 4
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        BITWIDTH4,
    input  logic        LOADSTART,
    input  logic        LOADTYPE,
    input  logic [10:0] PAGENUM,
    output logic        LOADBUSY,
    output logic        LOADDONE,
    output logic        nCS,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        nOUTBUFWRCLKEN,
    output logic [14:0] OUTBUFWRADDR,
    output logic        OUTBUFWRDATA
);

    state_t      state;
    logic        sck_en, sck_rise, sck_fall;
    logic [14:0] cnt, n_bits, base;
    logic [31:0] sr;
    logic [7:0]  hold_cnt;
    logic [23:0] page_addr;

    assign page_addr = 24'(PAGE_BASE + 32'(PAGENUM) * PAGE_STRIDE);
    assign sck_en    = state == ST_CMD || state == ST_ADDR || state == ST_DATA;

    spi_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck (
        .MCLK   (MCLK),
        .nRESET (nRESET),
        .en     (sck_en),
        .rise   (sck_rise),
        .fall   (sck_fall),
        .sck    (SCK)
    );

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state          <= ST_IDLE;
            nCS            <= 1'b1;
            MOSI           <= 1'b0;
            nOUTBUFWRCLKEN <= 1'b1;
            OUTBUFWRADDR   <= '0;
            OUTBUFWRDATA   <= 1'b0;
            LOADBUSY       <= 1'b0;
            LOADDONE       <= 1'b0;
            cnt            <= '0;
            n_bits         <= '0;
            base           <= '0;
            sr             <= '0;
            hold_cnt       <= '0;
        end else begin
            nOUTBUFWRCLKEN <= 1'b1;
            LOADDONE       <= 1'b0;
            // Command/address shift out on falling SCK; zeros follow, keeping MOSI low in DATA.
            if (sck_fall) begin
                MOSI <= sr[30];
                sr   <= {sr[30:0], 1'b0};
            end
            case (state)
                ST_IDLE: if (LOADSTART) begin
                    n_bits   <= bit_span(LOADTYPE ? PAGE_POS : BOOT_POS, BITWIDTH4);
                    base     <= LOADTYPE ? bit_span(USER_ORG, BITWIDTH4) : '0;
                    sr       <= {SPI_READ_CMD, LOADTYPE ? page_addr : BOOT_BASE};
                    MOSI     <= SPI_READ_CMD[7];
                    cnt      <= '0;
                    nCS      <= 1'b0;
                    LOADBUSY <= 1'b1;
                    state    <= ST_CMD;
                end
                ST_CMD: if (sck_rise) begin
                    cnt <= cnt + 15'd1;
                    if (cnt == 15'd7) state <= ST_ADDR;
                end
                ST_ADDR: if (sck_rise) begin
                    cnt <= cnt == 15'd31 ? '0 : cnt + 15'd1;
                    if (cnt == 15'd31) state <= ST_DATA;
                end
                ST_DATA: if (sck_rise) begin
                    nOUTBUFWRCLKEN <= 1'b0;
                    OUTBUFWRDATA   <= MISO;
                    OUTBUFWRADDR   <= base + cnt;
                    cnt            <= cnt + 15'd1;
                    if (cnt == n_bits - 15'd1) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    // Leaving DATA stops the divider, so SCK drops as nCS rises.
                    nCS      <= 1'b1;
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_cnt == 8'(CS_HOLD)) begin
                        state    <= ST_IDLE;
                        LOADBUSY <= 1'b0;
                        LOADDONE <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
